// File: rtl/health_shield_ctrl.sv
// Round sequencer and per-fighter health/shield bookkeeping for the two-player bar display.
// Define SHIELD_REGEN_EN to build the per-player shield regeneration counters.
module health_shield_ctrl #(
    parameter int MAX_HEALTH    = 10,
    parameter int MAX_SHIELD    = 10,
    parameter int HIT_DAMAGE    = 2,
    parameter int INVULN_CYCLES = 25000000,
    parameter int REGEN_CYCLES  = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       p1_block,
    input  logic       p2_block,
    output logic [3:0] p1_health,
    output logic [3:0] p1_shield,
    output logic [3:0] p2_health,
    output logic [3:0] p2_shield,
    output logic       p1_hit_ack,
    output logic       p2_hit_ack,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int CYC_MAX = (INVULN_CYCLES > REGEN_CYCLES) ? INVULN_CYCLES : REGEN_CYCLES;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);
    localparam logic [3:0] MAX_H = 4'(MAX_HEALTH);
    localparam logic [3:0] MAX_S = 4'(MAX_SHIELD);
    localparam logic [3:0] DMG   = 4'(HIT_DAMAGE);
    // The hit cycle itself is the first of the INVULN_CYCLES-long immune window.
    localparam logic [CNT_W-1:0] INV_LOAD = (INVULN_CYCLES > 0) ? CNT_W'(INVULN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef SHIELD_REGEN_EN
    localparam logic [CNT_W-1:0] REGEN_LAST = CNT_W'(REGEN_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIGHT = 2'd1,
        S_KO    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] ack_q, ack_d;
    logic       fight, load;
    logic [1:0] hit_on, blk, accept, zero_d;
    logic [7:0] health_v, shield_v;

    // Vectors are indexed by the fighter being hit: 0 = p1, 1 = p2.
    assign hit_on = {p1_hit, p2_hit};
    assign blk    = {p2_block, p1_block};
    assign fight  = (state_q == S_FIGHT);
    assign load   = start && (state_q != S_FIGHT);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            logic [3:0]       health_q, health_d, shield_q, shield_d;
            logic [CNT_W-1:0] inv_q, inv_d;
`ifdef SHIELD_REGEN_EN
            logic [CNT_W-1:0] regen_q, regen_d;
`endif

            assign accept[gi] = fight && hit_on[gi] && (inv_q == '0);

            always_comb begin
                health_d = health_q;
                shield_d = shield_q;
                inv_d    = inv_q;
`ifdef SHIELD_REGEN_EN
                regen_d  = regen_q;
`endif
                if (load) begin
                    health_d = MAX_H;
                    shield_d = MAX_S;
                    inv_d    = '0;
`ifdef SHIELD_REGEN_EN
                    regen_d  = '0;
`endif
                end else if (fight) begin
                    if (inv_q != '0) inv_d = inv_q - CNT_ONE;
                    if (accept[gi]) begin
                        if (blk[gi] && (shield_q != 4'd0)) shield_d = shield_q - 4'd1;
                        else health_d = (health_q > DMG) ? (health_q - DMG) : 4'd0;
                        inv_d = INV_LOAD;
`ifdef SHIELD_REGEN_EN
                        regen_d = '0;
`endif
                    end
`ifdef SHIELD_REGEN_EN
                    else if (blk[gi] || (shield_q >= MAX_S)) begin
                        regen_d = '0;
                    end else if (regen_q == REGEN_LAST) begin
                        shield_d = shield_q + 4'd1;
                        regen_d  = '0;
                    end else begin
                        regen_d = regen_q + CNT_ONE;
                    end
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    health_q <= MAX_H;
                    shield_q <= MAX_S;
                    inv_q    <= '0;
`ifdef SHIELD_REGEN_EN
                    regen_q  <= '0;
`endif
                end else begin
                    health_q <= health_d;
                    shield_q <= shield_d;
                    inv_q    <= inv_d;
`ifdef SHIELD_REGEN_EN
                    regen_q  <= regen_d;
`endif
                end
            end

            assign zero_d[gi]           = (health_d == 4'd0);
            assign health_v[gi*4 +: 4]  = health_q;
            assign shield_v[gi*4 +: 4]  = shield_q;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        // An accepted hit on p2 acknowledges p1's attack and vice versa.
        ack_d    = {accept[0], accept[1]};
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FIGHT;
            end
            S_FIGHT: begin
                if (|zero_d) begin
                    state_d  = S_KO;
                    winner_d = {zero_d[0], zero_d[1]};
                end
            end
            S_KO: begin
                if (start) begin
                    state_d  = S_FIGHT;
                    winner_d = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            winner_q <= 2'b00;
            ack_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ack_q    <= ack_d;
        end
    end

    assign p1_health  = health_v[3:0];
    assign p2_health  = health_v[7:4];
    assign p1_shield  = shield_v[3:0];
    assign p2_shield  = shield_v[7:4];
    assign p1_hit_ack = ack_q[0];
    assign p2_hit_ack = ack_q[1];
    assign game_over  = (state_q == S_KO);
    assign winner     = winner_q;

endmodule

// File: doc/health_shield_ctrl.md
Name: health_shield_ctrl

Overview:
- Owns the round-level health and shield state for both fighters.
- Converts attack/block events from the fighter logic into the 4-bit health/shield values consumed by the bar renderer.
- Sequences the round (idle, fight, KO), arbitrates simultaneous hits, enforces post-hit invulnerability and runs shield regeneration.
- Sits between the player input/hit-detection logic and the VGA bar display.

Parameters:
- MAX_HEALTH, 10: health value loaded at round start (≤15).
- MAX_SHIELD, 10: shield value loaded at round start and regen ceiling (≤15).
- HIT_DAMAGE, 2: health removed by one unblocked accepted hit.
- INVULN_CYCLES, 25000000: cycles a fighter ignores incoming hits after an accepted hit.
- REGEN_CYCLES, 100000000: non-blocking cycles needed to regain one shield point.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a round.
- p1_hit  in  1  one-cycle pulse; p1 lands an attack on p2.
- p2_hit  in  1  one-cycle pulse; p2 lands an attack on p1.
- p1_block  in  1  level; p1 holding block.
- p2_block  in  1  level; p2 holding block.
- p1_health  out  4  p1 health to bar display.
- p1_shield  out  4  p1 shield to bar display.
- p2_health  out  4  p2 health.
- p2_shield  out  4  p2 shield.
- p1_hit_ack  out  1  pulse; p1's attack was accepted.
- p2_hit_ack  out  1  pulse; p2's attack was accepted.
- game_over  out  1  high while in KO.
- winner  out  2  00 none, 01 p1, 10 p2, 11 draw.

Behaviour:

Reset (sync):
- State IDLE.
- Healths = MAX_HEALTH, shields = MAX_SHIELD.
- Acks 0, game_over 0, winner 00.
- Invulnerability and regen counters 0.
- Reset overrides all other inputs in the same cycle.

States:
- IDLE:
  - Values held at max; hits ignored.
  - start → FIGHT next cycle, with all values and counters reloaded.
- FIGHT:
  - Hits evaluated every cycle.
  - start ignored.
- KO:
  - game_over = 1; values frozen; hits ignored; winner holds.
  - start → FIGHT with reload; winner = 00, game_over = 0 on the same edge.

Hit acceptance, per direction; p1_hit targets p2, symmetric for p2_hit:
- Accepted only in FIGHT and only when the target invulnerability counter is 0.
- If the target is blocking and its shield > 0:
  - shield -= 1; health unchanged.
- Otherwise:
  - health = health − HIT_DAMAGE, saturating at 0.
- Also on acceptance:
  - Target invulnerability counter loads INVULN_CYCLES and decrements to 0 each cycle.
  - Attacker's ack pulses for 1 cycle.
- Timing:
  - Outputs are registered and change on the edge after the hit is sampled (latency 1).
  - Acks are asserted in that same cycle.
- Rejected hits produce no ack and no value change.
- Simultaneous p1_hit and p2_hit in the same cycle: each is evaluated and applied independently in that cycle; neither has priority.

KO detection:
- When a post-update health is 0, the state enters KO on the same edge as the update.
- winner = 01 if only p2 health is 0.
- winner = 10 if only p1 health is 0.
- winner = 11 if both are 0.

Shield regen, per player, FIGHT only:
- The counter increments each cycle when the player is not blocking and shield < MAX_SHIELD.
- When the counter reaches REGEN_CYCLES−1:
  - shield += 1; counter cleared.
- The counter clears when:
  - the player is blocking, or
  - the player receives an accepted hit, or
  - shield = MAX_SHIELD.
- An accepted hit and a regen completion in the same cycle: the hit wins; no regen increment.

Widths:
- Counters are sized with $clog2 of the larger cycle parameter.
- Health/shield arithmetic never wraps: saturate at 0 and at MAX.

Optional Feature:
- Macro: SHIELD_REGEN_EN.
- Defined: shield regeneration operates as specified.
- Undefined:
  - Regen counters and logic are removed.
  - Shields only decrease within a round and are restored to MAX_SHIELD solely by start or reset.
  - All other behaviour is identical.

Test Plan (bench parameters: INVULN_CYCLES=4, REGEN_CYCLES=8, defaults otherwise):
- reset, then start → next cycle all values 10/10, game_over=0, winner=00; p1_hit while IDLE → no change, no ack.
- FIGHT, p1_hit with p2_block=0 → next cycle p2_health=8, p1_hit_ack=1; second p1_hit 2 cycles later → rejected, p2_health stays 8; p1_hit 4 cycles after the first → p2_health=6.
- p2_block=1, shield=10, p1_hit → p2_shield=9, p2_health unchanged; with shield driven to 0 and blocking, p1_hit → health −2.
- p1_hit and p2_hit in the same cycle, both unblocked → both healths 8 one cycle later, both acks pulse.
- p2_health=2, p1_hit → p2_health=0, state KO, game_over=1, winner=01; further hits ignored; start → FIGHT, values 10, winner=00.
- SHIELD_REGEN_EN defined, p1_shield=9, p1_block=0 for 8 cycles → p1_shield=10; block asserted at cycle 5 → counter clears, no increment. Macro undefined → shield stays 9 indefinitely.
